// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard detection unit: op classes, default
// latencies and the scoreboard counter width helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_MUL    = 2'd2,
    OP_BRANCH = 2'd3
  } op_e;

  localparam int NREG_DEF     = 8;
  localparam int LOAD_LAT_DEF = 2;
  localparam int MUL_LAT_DEF  = 4;

  // Bits needed to hold a countdown value in the range 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// Decode/execute-side bundle into the hazard detection unit and its
// hazard-classification outputs toward the resolver.
interface hazard_detect_unit_if
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF
) ();
  localparam int RW = $clog2(NREG);

  logic          id_valid;
  op_e           id_op;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_we;
  logic          id_pred_taken;
  logic          ex_br_valid;
  logic          ex_br_taken;
  logic          stall_in;
  logic          flush_in;

  logic          data;
  logic          str;
  logic          ctrl;
  logic          fwrd;
  logic          branch;
  logic          crct;
  logic          issue;

  // Level-based, single-cycle contract: an instruction presented with
  // id_valid=1 advances exactly in a cycle where issue=1; otherwise it
  // must be held unchanged in decode until it does.
  modport master (
    output id_valid, id_op, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_pred_taken, ex_br_valid, ex_br_taken,
           stall_in, flush_in,
    input  data, str, ctrl, fwrd, branch, crct, issue
  );

  modport slave (
    input  id_valid, id_op, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_pred_taken, ex_br_valid, ex_br_taken,
           stall_in, flush_in,
    output data, str, ctrl, fwrd, branch, crct, issue
  );

endinterface

// File: rtl/hdu_scoreboard.sv
// Per-register countdown of cycles until a pending result is forwardable,
// with two source lookups reporting conflict and "forwardable next" (cnt==1).
module hdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int RW   = $clog2(NREG),
  parameter int CW   = cnt_width(MUL_LAT_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ld_en,
  input  logic [RW-1:0] i_ld_rd,
  input  logic [CW-1:0] i_ld_val,
  input  logic [RW-1:0] i_rs1,
  input  logic          i_use_rs1,
  input  logic [RW-1:0] i_rs2,
  input  logic          i_use_rs2,
  output logic          o_conf1,
  output logic          o_one1,
  output logic          o_conf2,
  output logic          o_one2
);

  logic [CW-1:0] r_cnt [NREG];

  // A new writer overrides the running decrement: last writer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_ld_en && (i_ld_rd == RW'(i))) begin
          r_cnt[i] <= i_ld_val;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  logic [CW-1:0] w_cnt1;
  logic [CW-1:0] w_cnt2;

  assign w_cnt1  = r_cnt[i_rs1];
  assign w_cnt2  = r_cnt[i_rs2];

  assign o_conf1 = i_use_rs1 && (i_rs1 != '0) && (w_cnt1 != '0);
  assign o_conf2 = i_use_rs2 && (i_rs2 != '0) && (w_cnt2 != '0);
  assign o_one1  = (w_cnt1 == CW'(1));
  assign o_one2  = (w_cnt2 == CW'(1));

endmodule

// File: rtl/hazard_detect_unit.sv
// Classifies data, structural and control hazards for the decode-stage
// instruction and decides whether it issues this cycle.
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_detect_unit_if.slave  bus
);

  localparam int RW = $clog2(NREG);
  localparam int CW = cnt_width(MUL_LAT);

  logic [CW-1:0] r_mul_busy;
  logic          r_br_pend;
  logic          r_br_pred;

  logic          w_conf1, w_one1, w_conf2, w_one2;
  logic          w_data, w_fwrd, w_str, w_issue;
  logic          w_ctrl, w_branch, w_crct;
  logic          w_ld_en;
  logic [CW-1:0] w_ld_val;

  always_comb begin
    w_ld_val = CW'(1);
    case (bus.id_op)
      OP_LOAD: w_ld_val = CW'(LOAD_LAT);
      OP_MUL:  w_ld_val = CW'(MUL_LAT);
      default: w_ld_val = CW'(1);
    endcase
  end

  assign w_ld_en = w_issue && bus.id_we && (bus.id_rd != '0) &&
                   (bus.id_op != OP_BRANCH);

  hdu_scoreboard #(
    .NREG (NREG),
    .RW   (RW),
    .CW   (CW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_ld_en   (w_ld_en),
    .i_ld_rd   (bus.id_rd),
    .i_ld_val  (w_ld_val),
    .i_rs1     (bus.id_rs1),
    .i_use_rs1 (bus.id_use_rs1),
    .i_rs2     (bus.id_rs2),
    .i_use_rs2 (bus.id_use_rs2),
    .o_conf1   (w_conf1),
    .o_one1    (w_one1),
    .o_conf2   (w_conf2),
    .o_one2    (w_one2)
  );

  // Forwarding is only possible once every conflicting source is one cycle out.
  assign w_data   = bus.id_valid && (w_conf1 || w_conf2);
  assign w_fwrd   = w_data && (!w_conf1 || w_one1) && (!w_conf2 || w_one2);
  assign w_str    = bus.id_valid && (bus.id_op == OP_MUL) && (r_mul_busy != '0);
  assign w_issue  = bus.id_valid && !bus.stall_in && !bus.flush_in &&
                    !(w_data && !w_fwrd) && !w_str && !r_br_pend;
  assign w_ctrl   = r_br_pend ||
                    (bus.id_valid && (bus.id_op == OP_BRANCH) && !w_issue);
  assign w_branch = r_br_pend && bus.ex_br_valid;
  assign w_crct   = !w_branch || (bus.ex_br_taken == r_br_pred);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_busy <= '0;
      r_br_pend  <= 1'b0;
      r_br_pred  <= 1'b0;
    end else begin
      if (w_issue && (bus.id_op == OP_MUL)) begin
        r_mul_busy <= CW'(MUL_LAT);
      end else if (r_mul_busy != '0) begin
        r_mul_busy <= r_mul_busy - 1'b1;
      end
      // Nothing issues while a branch is pending, so set and clear never collide.
      if (w_branch || bus.flush_in) begin
        r_br_pend <= 1'b0;
      end else if (w_issue && (bus.id_op == OP_BRANCH)) begin
        r_br_pend <= 1'b1;
        r_br_pred <= bus.id_pred_taken;
      end
    end
  end

  assign bus.data   = !rst && w_data;
  assign bus.str    = !rst && w_str;
  assign bus.ctrl   = !rst && w_ctrl;
  assign bus.fwrd   = !rst && w_fwrd;
  assign bus.branch = !rst && w_branch;
  assign bus.crct   = rst || w_crct;
  assign bus.issue  = !rst && w_issue;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed scenarios plus random traffic,
// all checked every cycle against a time-stamp based reference model.
module tb_hazard_detect_unit;
  import hazard_pkg::*;

  localparam int NREG     = 8;
  localparam int LOAD_LAT = 2;
  localparam int MUL_LAT  = 4;

  logic clk;
  logic rst;

  hazard_detect_unit_if #(.NREG(NREG)) bus ();

  hazard_detect_unit #(
    .NREG     (NREG),
    .LOAD_LAT (LOAD_LAT),
    .MUL_LAT  (MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: absolute cycle at which each register / the multiplier
  // becomes free, rather than per-cycle countdowns.
  int ready_at [NREG];
  int mul_free_at;
  bit m_br_pend;
  bit m_br_pred;
  int now;
  bit last_issue;

  logic [6:0] exp_q[$];

  function automatic int lat_of(input op_e op);
    case (op)
      OP_LOAD: return LOAD_LAT;
      OP_MUL:  return MUL_LAT;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) ready_at[i] = 0;
    mul_free_at = 0;
    m_br_pend   = 1'b0;
    m_br_pred   = 1'b0;
  endtask

  // Outputs packed as {data, str, ctrl, fwrd, branch, crct, issue}.
  task automatic cycle_check();
    bit c1, c2, f1, f2, e_data, e_fwrd, e_str, e_issue, e_ctrl, e_branch, e_crct;
    logic [6:0] e_vec, got_vec;
    @(negedge clk);
    c1 = bus.id_use_rs1 && bus.id_rs1 != 0 && (ready_at[bus.id_rs1] - now) > 0;
    c2 = bus.id_use_rs2 && bus.id_rs2 != 0 && (ready_at[bus.id_rs2] - now) > 0;
    f1 = (ready_at[bus.id_rs1] - now) == 1;
    f2 = (ready_at[bus.id_rs2] - now) == 1;
    e_data   = bus.id_valid && (c1 || c2);
    e_fwrd   = e_data && (!c1 || f1) && (!c2 || f2);
    e_str    = bus.id_valid && bus.id_op == OP_MUL && now < mul_free_at;
    e_issue  = bus.id_valid && !bus.stall_in && !bus.flush_in &&
               !(e_data && !e_fwrd) && !e_str && !m_br_pend;
    e_ctrl   = m_br_pend || (bus.id_valid && bus.id_op == OP_BRANCH && !e_issue);
    e_branch = m_br_pend && bus.ex_br_valid;
    e_crct   = !e_branch || (bus.ex_br_taken == m_br_pred);
    if (rst) e_vec = 7'b0000010;
    else     e_vec = {e_data, e_str, e_ctrl, e_fwrd, e_branch, e_crct, e_issue};
    exp_q.push_back(e_vec);
    got_vec = {bus.data, bus.str, bus.ctrl, bus.fwrd, bus.branch, bus.crct, bus.issue};
    e_vec = exp_q.pop_front();
    check("data",   32'(got_vec[6]), 32'(e_vec[6]));
    check("str",    32'(got_vec[5]), 32'(e_vec[5]));
    check("ctrl",   32'(got_vec[4]), 32'(e_vec[4]));
    check("fwrd",   32'(got_vec[3]), 32'(e_vec[3]));
    check("branch", 32'(got_vec[2]), 32'(e_vec[2]));
    check("crct",   32'(got_vec[1]), 32'(e_vec[1]));
    check("issue",  32'(got_vec[0]), 32'(e_vec[0]));
    last_issue = e_vec[0];
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_issue && bus.id_we && bus.id_rd != 0 && bus.id_op != OP_BRANCH)
        ready_at[bus.id_rd] = now + 1 + lat_of(bus.id_op);
      if (e_issue && bus.id_op == OP_MUL) mul_free_at = now + 1 + MUL_LAT;
      if (e_branch || bus.flush_in) m_br_pend = 1'b0;
      else if (e_issue && bus.id_op == OP_BRANCH) begin
        m_br_pend = 1'b1;
        m_br_pred = bus.id_pred_taken;
      end
    end
    now++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_op = OP_ALU; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = 0; bus.id_we = 0;
    bus.id_pred_taken = 0; bus.ex_br_valid = 0; bus.ex_br_taken = 0;
    bus.stall_in = 0; bus.flush_in = 0;
  endtask

  // Present an instruction and hold it until it issues (bounded wait).
  task automatic run_instr(input op_e op, input int rs1, input bit u1, input int rs2,
                           input bit u2, input int rd, input bit we, input bit pred);
    int budget;
    bus.id_valid = 1; bus.id_op = op;
    bus.id_rs1 = 3'(rs1); bus.id_use_rs1 = u1;
    bus.id_rs2 = 3'(rs2); bus.id_use_rs2 = u2;
    bus.id_rd = 3'(rd); bus.id_we = we; bus.id_pred_taken = pred;
    budget = 0;
    do begin
      cycle_check();
      budget++;
    end while (!last_issue && budget < 16);
    if (!last_issue) check("issue_timeout", 32'd0, 32'd1);
    bus.id_valid = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  initial begin
    now = 0;
    last_issue = 0;
    model_reset();
    idle_inputs();
    rst = 1;
    #1;
    idle_cycles(2);
    rst = 0;
    idle_cycles(1);

    // ALU -> dependent ALU: forwardable on the next cycle
    run_instr(OP_ALU, 0, 0, 0, 0, 3, 1, 0);
    run_instr(OP_ALU, 3, 1, 0, 0, 1, 1, 0);
    idle_cycles(2);

    // LOAD -> dependent: one stall cycle, then forwarded
    run_instr(OP_LOAD, 0, 0, 0, 0, 2, 1, 0);
    run_instr(OP_ALU, 0, 0, 2, 1, 6, 1, 0);
    idle_cycles(3);

    // Back-to-back MUL: structural stall while multiplier busy
    run_instr(OP_MUL, 0, 0, 0, 0, 4, 1, 0);
    run_instr(OP_MUL, 1, 1, 0, 0, 5, 1, 0);
    idle_cycles(5);

    // Correctly predicted taken branch
    run_instr(OP_BRANCH, 1, 1, 2, 1, 0, 0, 1);
    idle_cycles(1);
    bus.ex_br_valid = 1; bus.ex_br_taken = 1;
    idle_cycles(1);
    bus.ex_br_valid = 0;
    idle_cycles(1);

    // Mispredicted branch followed by a flush
    run_instr(OP_BRANCH, 0, 0, 0, 0, 0, 0, 1);
    idle_cycles(1);
    bus.ex_br_valid = 1; bus.ex_br_taken = 0;
    idle_cycles(1);
    bus.ex_br_valid = 0; bus.flush_in = 1;
    bus.id_valid = 1; bus.id_op = OP_ALU;
    idle_cycles(1);
    bus.flush_in = 0; bus.id_valid = 0;
    idle_cycles(1);

    // Reset with a LOAD to r5 in flight
    run_instr(OP_LOAD, 0, 0, 0, 0, 5, 1, 0);
    rst = 1;
    idle_cycles(1);
    rst = 0;
    bus.id_valid = 1; bus.id_op = OP_ALU; bus.id_rs1 = 3'd5; bus.id_use_rs1 = 1;
    idle_cycles(1);
    idle_inputs();

    // Random traffic; the decode instruction is held while it waits to issue
    for (int n = 0; n < 1500; n++) begin
      if (!bus.id_valid || last_issue || bus.flush_in) begin
        bus.id_valid      = ($urandom_range(0, 3) != 0);
        bus.id_op         = op_e'($urandom_range(0, 3));
        bus.id_rs1        = 3'($urandom_range(0, NREG - 1));
        bus.id_rs2        = 3'($urandom_range(0, NREG - 1));
        bus.id_use_rs1    = 1'($urandom_range(0, 1));
        bus.id_use_rs2    = 1'($urandom_range(0, 1));
        bus.id_rd         = 3'($urandom_range(0, NREG - 1));
        bus.id_we         = ($urandom_range(0, 3) != 0);
        bus.id_pred_taken = 1'($urandom_range(0, 1));
      end
      bus.ex_br_valid = ($urandom_range(0, 3) == 0);
      bus.ex_br_taken = 1'($urandom_range(0, 1));
      bus.stall_in    = ($urandom_range(0, 7) == 0);
      bus.flush_in    = ($urandom_range(0, 15) == 0);
      rst             = ($urandom_range(0, 63) == 0);
      cycle_check();
    end
    rst = 0;
    idle_inputs();
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Upstream neighbour of the FSM hazard resolver.
- Watches the decode-stage instruction and a small in-flight scoreboard, then produces the six hazard-classification signals the resolver consumes: data, str, ctrl, fwrd, branch, crct.
- The resolver's stall/flush decisions feed back in through stall_in/flush_in, which control when an instruction issues.

Parameters:
- NREG, 8: architectural registers; register ids are clog2(NREG) bits; r0 never hazards.
- LOAD_LAT, 2: cycles after issue before a load result is forwardable.
- MUL_LAT, 4: cycles the non-pipelined multiplier is busy; also the cycles until its result is forwardable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_op  in  2  op class: 0 ALU, 1 LOAD, 2 MUL, 3 BRANCH.
- id_rs1, id_rs2  in  clog2(NREG)  source register ids.
- id_use_rs1, id_use_rs2  in  1  source register is actually read.
- id_rd  in  clog2(NREG)  destination register id.
- id_we  in  1  instruction writes id_rd.
- id_pred_taken  in  1  static prediction for a BRANCH.
- ex_br_valid  in  1  execute reports branch resolution this cycle.
- ex_br_taken  in  1  actual branch outcome.
- stall_in  in  1  resolver stall; decode does not advance.
- flush_in  in  1  resolver flush.
- data, str, ctrl, fwrd, branch, crct  out  1 each  hazard signals to the resolver.
- issue  out  1  decode instruction advances this cycle.

Behaviour:
- Reset (rst=1 at a clock edge) clears all state:
  - per-register pending counters = 0;
  - mul_busy = 0;
  - br_pend = 0, br_pred = 0.
- While rst=1, outputs are forced to idle values: data=0, str=0, ctrl=0, fwrd=0, branch=0, crct=1, issue=0.
- All outputs are combinational from registered state plus current id_*/ex_* inputs. There is zero added latency.
- Scoreboard:
  - one counter per register, width clog2(MUL_LAT+1);
  - every cycle, each nonzero counter decrements by 1;
  - on issue with id_we=1 and id_rd!=0, cnt[id_rd] is loaded with 1 (ALU), LOAD_LAT (LOAD) or MUL_LAT (MUL). The load overrides the decrement for that register;
  - BRANCH never writes.
- Source hazard: a source conflicts when id_use_rsN=1, rsN!=0 and cnt[rsN]!=0.
- data = id_valid & (any source conflicts).
- fwrd = data & (every conflicting source has cnt==1). Otherwise fwrd=0.
  - If both sources conflict with different counts, fwrd=0 until both counters reach 1.
- Structural: mul_busy is loaded with MUL_LAT on MUL issue and decrements to 0.
  - str = id_valid & id_op==MUL & mul_busy!=0.
- Control:
  - On BRANCH issue, set br_pend=1 and latch br_pred=id_pred_taken.
  - ctrl = br_pend | (id_valid & id_op==BRANCH & ~issue).
  - branch = br_pend & ex_br_valid.
  - crct = ~branch | (ex_br_taken==br_pred).
  - br_pend clears on the cycle branch=1, or on flush_in.
  - ex_br_valid while br_pend=0 is ignored: branch=0, crct=1.
- Issue rule:
  - issue = id_valid & ~stall_in & ~flush_in & ~data_unfwd & ~str & ~br_pend, where data_unfwd = data & ~fwrd.
  - A forwardable data hazard does not block issue.
- Boundaries:
  - No instruction issues in a branch shadow. Therefore flush_in never needs to undo scoreboard entries; flush_in only clears br_pend.
  - An instruction writing a register whose counter is nonzero reloads it (last writer wins).
  - rst mid-operation discards all pending counts and any branch in flight.

Decomposition:
- Shared package hazard_pkg holds:
  - op class enum (OP_ALU, OP_LOAD, OP_MUL, OP_BRANCH);
  - default NREG/LOAD_LAT/MUL_LAT constants;
  - counter-width function.
- One sub-module, hdu_scoreboard: counter array, decrement/load logic, and the two source-lookup ports returning conflict and cnt==1.

Test Plan:
- ALU writes r3, next instruction reads r3 -> data=1, fwrd=1, issue=1 in that cycle; next cycle data=0.
- LOAD writes r2 (LOAD_LAT=2), next instruction reads r2 -> cycle 1: data=1, fwrd=0, issue=0; cycle 2: data=1, fwrd=1, issue=1.
- MUL issued, second MUL in decode -> str=1 for 4 cycles (mul_busy 4..1), then str=0 and issue=1.
- BRANCH pred_taken=1 issued; 2 cycles later ex_br_valid=1, taken=1 -> ctrl=1 throughout, branch=1, crct=1 on the resolve cycle, br_pend cleared.
- Same with ex_br_taken=0 -> branch=1, crct=0; then flush_in=1 -> issue=0, ctrl=0 next cycle.
- LOAD to r5 in flight, assert rst -> next cycle all outputs idle, and a read of r5 gives data=0.
